// File: rtl/vfx_stream_pkg.sv
// vfx_stream_pkg
//   Shared types and constants for the video streaming blocks.
//   - VFX_IN_WIDTH / VFX_IN_HEIGHT : default input frame geometry
//   - CH_W   : bits per colour channel (RGB444)
//   - PAIR_W : width of a two-pixel channel sum
//   - QUAD_W : width of a four-pixel channel sum
//   - rgb444_t   : packed pixel, R[11:8] G[7:4] B[3:0]
//   - pair_sum_t : three packed pair sums (15 bits), the line-buffer word
package vfx_stream_pkg;

  localparam int unsigned VFX_IN_WIDTH  = 320;
  localparam int unsigned VFX_IN_HEIGHT = 240;
  localparam int unsigned CH_W          = 4;
  localparam int unsigned PAIR_W        = 5;
  localparam int unsigned QUAD_W        = 6;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [PAIR_W-1:0] r;
    logic [PAIR_W-1:0] g;
    logic [PAIR_W-1:0] b;
  } pair_sum_t;

  function automatic pair_sum_t pair_add(input rgb444_t a, input rgb444_t b);
    pair_sum_t s;
    s.r = {1'b0, a.r} + {1'b0, b.r};
    s.g = {1'b0, a.g} + {1'b0, b.g};
    s.b = {1'b0, a.b} + {1'b0, b.b};
    return s;
  endfunction

  // Average of two pair sums, truncated (no rounding).
  function automatic rgb444_t quad_avg(input pair_sum_t a, input pair_sum_t b);
    logic [QUAD_W-1:0] sr;
    logic [QUAD_W-1:0] sg;
    logic [QUAD_W-1:0] sb;
    rgb444_t           p;
    sr  = {1'b0, a.r} + {1'b0, b.r};
    sg  = {1'b0, a.g} + {1'b0, b.g};
    sb  = {1'b0, a.b} + {1'b0, b.b};
    p.r = sr[QUAD_W-1:2];
    p.g = sg[QUAD_W-1:2];
    p.b = sb[QUAD_W-1:2];
    return p;
  endfunction

endpackage

// File: rtl/downscale_line_buffer.sv
// downscale_line_buffer
//   Single-row store of horizontal pair sums between an even and odd line.
//   Simple dual-port, write-first-free, registered read: maps onto one BRAM.
//   Ports:
//     clk      : clock
//     wr_en_i  : write strobe
//     wr_addr_i: write address (pixel pair index)
//     wr_data_i: packed pair sums
//     rd_en_i  : read strobe; rd_data_o updates on the next rising edge
//     rd_addr_i: read address
//     rd_data_o: registered read data, held while rd_en_i is low
module downscale_line_buffer #(
  parameter int DEPTH = 160,
  parameter int AW    = 8,
  parameter int DW    = 15
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_downscale_2x.sv
// stream_downscale_2x
//   2x2 box-filter downscaler for an RGB444 pixel stream with
//   valid/ready handshake and start/end-of-packet framing.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     in_data/in_valid    : upstream pixel and its valid
//     in_ready            : pixel accepted this cycle when in_valid is high
//     in_startofpacket    : pixel is (0,0) of a frame; resyncs position
//     in_endofpacket      : last pixel of a frame; next pixel is (0,0)
//     out_data/out_valid  : averaged pixel, registered
//     out_ready           : downstream accept
//     out_startofpacket   : with output pixel (0,0)
//     out_endofpacket     : with the last output pixel of a full frame
module stream_downscale_2x
  import vfx_stream_pkg::*;
#(
  parameter int IN_WIDTH   = VFX_IN_WIDTH,
  parameter int IN_HEIGHT  = VFX_IN_HEIGHT,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket
);

  localparam int XW = $clog2(IN_WIDTH);
  localparam int YW = $clog2(IN_HEIGHT);
  localparam int AW = XW - 1;

  logic [XW-1:0] x_q, x_d, x_eff;
  logic [YW-1:0] y_q, y_d, y_eff;
  logic          accept, odd_x, odd_y, last_x, last_y, load;

  rgb444_t       in_px, hold_q;
  pair_sum_t     pair_cur, pair_above;

  rgb444_t       out_px_q, out_px_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_px    = in_data;

  // A start-of-packet pixel is (0,0) no matter where the counters stand.
  assign x_eff  = in_startofpacket ? '0 : x_q;
  assign y_eff  = in_startofpacket ? '0 : y_q;
  assign odd_x  = x_eff[0];
  assign odd_y  = y_eff[0];
  assign last_x = (x_eff == XW'(IN_WIDTH - 1));
  assign last_y = (y_eff == YW'(IN_HEIGHT - 1));

  assign pair_cur = pair_add(hold_q, in_px);
  assign load     = accept && odd_x && odd_y;

  // Even rows park their pair sums; odd rows fetch them one pixel early so
  // the registered read is ready by the odd-x pixel.
  downscale_line_buffer #(
    .DEPTH(IN_WIDTH / 2),
    .AW   (AW),
    .DW   (3 * PAIR_W)
  ) u_line_buffer (
    .clk      (clk),
    .wr_en_i  (accept && odd_x && !odd_y),
    .wr_addr_i(x_eff[XW-1:1]),
    .wr_data_i(pair_cur),
    .rd_en_i  (accept && !odd_x && odd_y),
    .rd_addr_i(x_eff[XW-1:1]),
    .rd_data_o(pair_above)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (in_endofpacket) begin
        x_d = '0;
        y_d = '0;
      end else if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_eff + 1'b1;
      end else begin
        x_d = x_eff + 1'b1;
        y_d = y_eff;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_px_d    = out_px_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_px_d    = quad_avg(pair_above, pair_cur);
      out_sop_d   = (x_eff == XW'(1)) && (y_eff == YW'(1));
      out_eop_d   = last_x && last_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_px_q    <= out_px_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  // Left pixel of each horizontal pair; no reset needed, always rewritten
  // before use.
  always_ff @(posedge clk) begin
    if (accept && !odd_x) begin
      hold_q <= in_px;
    end
  end

  assign out_data          = out_px_q;
  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;

endmodule

// File: doc/stream_downscale_2x.md
STREAM_DOWNSCALE_2X -- requirements
Module: stream_downscale_2x

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 320, meaning input pixels per line (even).
REQ-002 SHALL have parameter IN_HEIGHT, default 240, meaning input lines per frame (even).
REQ-003 SHALL have parameter DATA_WIDTH, default 12, meaning pixel width, RGB444 packed R[11:8] G[7:4] B[3:0].
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  upstream pixel.
REQ-007 SHALL have port in_valid  input  1  upstream pixel valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port in_startofpacket  input  1  first pixel of input frame.
REQ-010 SHALL have port in_endofpacket  input  1  last pixel of input frame.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  downscaled pixel.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have port out_startofpacket  output  1  first pixel of output frame.
REQ-015 SHALL have port out_endofpacket  output  1  last pixel of output frame.

Function
REQ-016 SHALL produce one output pixel per 2x2 input block: (IN_WIDTH/2) x (IN_HEIGHT/2) = 160x120 default.
REQ-017 SHALL accept an input pixel only on in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-018 SHALL track input position with column counter x (0..IN_WIDTH-1) and row counter y (0..IN_HEIGHT-1), advancing on each accept; x wraps to 0 and y increments at x = IN_WIDTH-1; both wrap to 0 after (IN_WIDTH-1, IN_HEIGHT-1).
REQ-019 SHALL, per channel, hold the even-x pixel and on the odd-x accept form a 5-bit horizontal pair sum.
REQ-020 SHALL, on even y, write the three 5-bit pair sums (15 bits) to line buffer address x>>1 on the odd-x accept.
REQ-021 SHALL, on odd y, issue line-buffer read at address x>>1 on the even-x accept; read data valid by the following odd-x accept.
REQ-022 SHALL, on odd-x odd-y accept, compute per channel 6-bit sum = stored pair sum + current pair sum, output channel = sum[5:2] (truncation, no rounding).
REQ-023 SHALL register the result: out_valid asserts the cycle after the odd-x odd-y accept; latency exactly 1 cycle from that accept.
REQ-024 SHALL hold out_data, out_valid, out_startofpacket, out_endofpacket stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid after out_valid && out_ready unless a new result loads the same cycle.
REQ-026 SHALL assert out_startofpacket with output pixel (0,0) and out_endofpacket with output pixel (IN_WIDTH/2-1, IN_HEIGHT/2-1) only.
REQ-027 SHALL, on accepting in_startofpacket, treat that pixel as x=0, y=0 regardless of counters (mid-frame resync; partial frame output abandoned, no EOP emitted for it).
REQ-028 SHALL, on accepting in_endofpacket, force counters to 0 for the next pixel; an early EOP emits no further outputs for that frame.
REQ-029 SHALL ignore in_data while in_valid is low; counters hold.

Reset
REQ-030 SHALL, on reset, set x=0, y=0, out_valid=0, out_startofpacket=0, out_endofpacket=0, out_data=0; in_ready reads 1 during and after reset.
REQ-031 SHALL, on reset mid-frame, discard partial state; line buffer contents not cleared (overwritten by next even row).

Structure
REQ-032 SHALL place IN_WIDTH/IN_HEIGHT defaults, channel width (4), pair-sum width (5), and a packed RGB444 pixel typedef in shared package vfx_stream_pkg.
REQ-033 SHALL implement the line buffer as sub-module downscale_line_buffer: IN_WIDTH/2 x 15-bit, one write port, one registered read port with read enable, BRAM-inferable.

Verification
REQ-034 SHALL verify: constant frame 0xF0A, out_ready=1 -> 19200 outputs all 0xF0A, SOP on 1st, EOP on 19200th only.
REQ-035 SHALL verify: block {0x444,0x000 / 0x000,0x000} -> 0x111; block {0x003,0x000 / 0x000,0x000} -> 0x000 (truncation); block {0xFFF x4} -> 0xFFF.
REQ-036 SHALL verify: out_ready low 5 cycles with out_valid high -> in_ready low, outputs stable 5 cycles, no pixel lost or duplicated.
REQ-037 SHALL verify: reset asserted at input pixel 1000 then new frame -> first output SOP, 19200 correct outputs.
REQ-038 SHALL verify: in_startofpacket at input pixel 700 -> counters resync, following frame yields 19200 outputs, EOP only at last.
REQ-039 SHALL verify: random in_valid and out_ready (50%) over 2 frames -> output matches reference model bit-exact.
